// File: rtl/hasti_interconnect_pkg.sv
// pk_hasti: shared AHB-Lite types for the hasti interconnect slice.
//   htrans_t   - transfer type encoding
//   hresp_t    - response encoding
//   ds_state_t - default-slave FSM states
//   wd_state_t - wait-state watchdog states
//   MAX_SLAVES - upper limit for the NSLAVES parameter
package pk_hasti;

  localparam int unsigned MAX_SLAVES = 16;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR0 = 2'd1,
    DS_ERR1 = 2'd2
  } ds_state_t;

  typedef enum logic {
    WD_RUN  = 1'b0,
    WD_ERR1 = 1'b1
  } wd_state_t;

  // NONSEQ and SEQ are the only transfer types that demand a response.
  function automatic logic is_xfer(htrans_t t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/hasti_interconnect_if.sv
// AHB-Lite bundles used by hasti_interconnect.
//   if_hasti_master_io.f : interconnect view of the master
//     in : haddr htrans hwrite hsize hburst hprot hmastlock hwdata
//     out: hrdata hresp hready
//   if_hasti_slave_io.f  : interconnect view of one slave
//     out: hsel hready haddr htrans hwrite hsize hburst hprot hmastlock hwdata
//     in : hrdata hresp hreadyout
interface if_hasti_master_io;
  logic [31:0]      haddr;
  pk_hasti::htrans_t htrans;
  logic             hwrite;
  logic [2:0]       hsize;
  logic [2:0]       hburst;
  logic [3:0]       hprot;
  logic             hmastlock;
  logic [31:0]      hwdata;
  logic [31:0]      hrdata;
  pk_hasti::hresp_t hresp;
  logic             hready;

  modport f (
    input  haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
    output hrdata, hresp, hready
  );
endinterface

interface if_hasti_slave_io;
  logic             hsel;
  logic             hready;
  logic [31:0]      haddr;
  pk_hasti::htrans_t htrans;
  logic             hwrite;
  logic [2:0]       hsize;
  logic [2:0]       hburst;
  logic [3:0]       hprot;
  logic             hmastlock;
  logic [31:0]      hwdata;
  logic [31:0]      hrdata;
  pk_hasti::hresp_t hresp;
  logic             hreadyout;

  modport f (
    output hsel, hready, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
    input  hrdata, hresp, hreadyout
  );
endinterface

// File: rtl/hasti_default_slave.sv
// hasti_default_slave: answers every transfer that decodes to no slave.
// Transfers (NONSEQ/SEQ) get the two-cycle AHB ERROR response, IDLE/BUSY
// get a zero-wait OKAY. Outputs are registered alongside the state.
//
// Ports:
//   hclk      in  bus clock
//   hreset    in  synchronous active-high reset
//   htrans    in  address-phase transfer type
//   hsel      in  address decodes to no mapped slave
//   hready    in  bus hready (address phase accepted when 1)
//   hresp     out data-phase response
//   hreadyout out data-phase ready
//
// state   | meaning
// --------+------------------------------------------------
// DS_IDLE | no error pending, OKAY with zero wait
// DS_ERR0 | first ERROR cycle, hreadyout=0
// DS_ERR1 | second ERROR cycle, hreadyout=1, may accept next
module hasti_default_slave
  import pk_hasti::*;
(
  input  logic    hclk,
  input  logic    hreset,
  input  htrans_t htrans,
  input  logic    hsel,
  input  logic    hready,
  output hresp_t  hresp,
  output logic    hreadyout
);

  ds_state_t state;
  logic      start;

  // Only an accepted address phase may launch an error; a stalled data
  // phase of a mapped slave holds hready low and so blocks this.
  assign start = hready && hsel && is_xfer(htrans);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= DS_IDLE;
      hresp     <= HRESP_OKAY;
      hreadyout <= 1'b1;
    end else begin
      case (state)
        DS_IDLE: begin
          if (start) begin
            state     <= DS_ERR0;
            hresp     <= HRESP_ERROR;
            hreadyout <= 1'b0;
          end
        end
        DS_ERR0: begin
          state     <= DS_ERR1;
          hresp     <= HRESP_ERROR;
          hreadyout <= 1'b1;
        end
        DS_ERR1: begin
          if (start) begin
            state     <= DS_ERR0;
            hresp     <= HRESP_ERROR;
            hreadyout <= 1'b0;
          end else begin
            state     <= DS_IDLE;
            hresp     <= HRESP_OKAY;
            hreadyout <= 1'b1;
          end
        end
        default: begin
          state     <= DS_IDLE;
          hresp     <= HRESP_OKAY;
          hreadyout <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/hasti_interconnect.sv
// hasti_interconnect: single-master AHB-Lite address decoder and
// data-phase multiplexer for NSLAVES slaves plus an internal default slave.
//
// Parameters:
//   NSLAVES        number of slave ports (1..MAX_SLAVES)
//   BASE/MASK      slave i decodes when (haddr & MASK[i]) == BASE[i];
//                  lowest index wins on overlap
//   TIMEOUT_CYCLES wait-state limit for the optional watchdog (2..65535)
//
// Ports:
//   hclk    in   bus clock
//   hreset  in   synchronous active-high reset
//   m       master bundle (if_hasti_master_io.f)
//   s[]     slave bundles (if_hasti_slave_io.f)
//
// Optional feature: define HASTI_INTERCONNECT_TIMEOUT_EN to build the
// wait-state watchdog that terminates an over-long stall with ERROR.
module hasti_interconnect
  import pk_hasti::*;
#(
  parameter int unsigned NSLAVES              = 3,
  parameter logic [31:0] BASE [NSLAVES]       = '{32'h0000_0000, 32'h2000_0000, 32'h8000_0000},
  parameter logic [31:0] MASK [NSLAVES]       = '{32'hFFFF_F000, 32'hFFFF_F000, 32'h8000_0000},
  parameter int unsigned TIMEOUT_CYCLES       = 16
) (
  input logic         hclk,
  input logic         hreset,
  if_hasti_master_io.f m,
  if_hasti_slave_io.f  s [NSLAVES]
);

  if (NSLAVES < 1 || NSLAVES > MAX_SLAVES) begin : g_bad_nslaves
    $error("hasti_interconnect: NSLAVES out of range");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("hasti_interconnect: TIMEOUT_CYCLES out of range");
  end

  logic [NSLAVES-1:0] dec_oh;
  logic               dec_none;
  logic [NSLAVES-1:0] sel_oh_r;
  logic               mapped_r;

  logic [31:0]        s_hrdata [NSLAVES];
  logic [NSLAVES-1:0] s_hresp;
  logic [NSLAVES-1:0] s_hreadyout;

  hresp_t             dflt_hresp;
  logic               dflt_hreadyout;

  logic [31:0]        mux_rdata;
  logic               mux_resp;
  logic               mux_ready;
  logic               wd_err0;
  logic               wd_err1;
  logic               bus_resp;
  logic               bus_ready;

  // Walk high to low so the lowest matching index ends up owning the hit.
  always_comb begin
    dec_oh = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((m.haddr & MASK[i]) == BASE[i]) begin
        dec_oh    = '0;
        dec_oh[i] = 1'b1;
      end
    end
  end

  assign dec_none = ~|dec_oh;

  for (genvar g = 0; g < NSLAVES; g++) begin : g_slv
    assign s[g].hsel      = dec_oh[g];
    assign s[g].hready    = bus_ready;
    assign s[g].haddr     = m.haddr;
    assign s[g].htrans    = m.htrans;
    assign s[g].hwrite    = m.hwrite;
    assign s[g].hsize     = m.hsize;
    assign s[g].hburst    = m.hburst;
    assign s[g].hprot     = m.hprot;
    assign s[g].hmastlock = m.hmastlock;
    assign s[g].hwdata    = m.hwdata;
    assign s_hrdata[g]    = s[g].hrdata;
    assign s_hresp[g]     = (s[g].hresp == HRESP_ERROR);
    assign s_hreadyout[g] = s[g].hreadyout;
  end

  // All-zero sel_oh_r means the default slave owns the data phase.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      sel_oh_r <= '0;
    end else if (bus_ready) begin
      sel_oh_r <= dec_oh;
    end
  end

  assign mapped_r = |sel_oh_r;

  hasti_default_slave u_dflt (
    .hclk      (hclk),
    .hreset    (hreset),
    .htrans    (m.htrans),
    .hsel      (dec_none),
    .hready    (bus_ready),
    .hresp     (dflt_hresp),
    .hreadyout (dflt_hreadyout)
  );

  always_comb begin
    mux_rdata = '0;
    mux_resp  = (dflt_hresp == HRESP_ERROR);
    mux_ready = dflt_hreadyout;
    for (int i = 0; i < NSLAVES; i++) begin
      if (sel_oh_r[i]) begin
        mux_rdata = s_hrdata[i];
        mux_resp  = s_hresp[i];
        mux_ready = s_hreadyout[i];
      end
    end
  end

`ifdef HASTI_INTERCONNECT_TIMEOUT_EN
  logic [15:0] wd_cnt;
  wd_state_t   wd_state;
  logic        wd_stall;
  logic        wd_hit;

  assign wd_stall = mapped_r && !mux_ready;
  // A slave raising hreadyout on the limit cycle clears wd_stall and wins.
  assign wd_hit   = (wd_state == WD_RUN) && wd_stall &&
                    (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign wd_err0  = wd_hit;
  assign wd_err1  = (wd_state == WD_ERR1);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      wd_cnt   <= '0;
      wd_state <= WD_RUN;
    end else begin
      case (wd_state)
        WD_RUN: begin
          if (wd_hit) begin
            wd_state <= WD_ERR1;
            wd_cnt   <= '0;
          end else if (wd_stall) begin
            wd_cnt <= wd_cnt + 16'd1;
          end else begin
            wd_cnt <= '0;
          end
        end
        default: begin
          wd_state <= WD_RUN;
          wd_cnt   <= '0;
        end
      endcase
    end
  end
`else
  assign wd_err0 = 1'b0;
  assign wd_err1 = 1'b0;
`endif

  // The watchdog response replaces the stalled slave's response; its
  // second cycle drives hready=1 so the slave sees its data phase end.
  always_comb begin
    bus_resp  = mux_resp;
    bus_ready = mux_ready;
    if (wd_err0) begin
      bus_resp  = 1'b1;
      bus_ready = 1'b0;
    end else if (wd_err1) begin
      bus_resp  = 1'b1;
      bus_ready = 1'b1;
    end
  end

  assign m.hrdata = mux_rdata;
  assign m.hresp  = hresp_t'(bus_resp);
  assign m.hready = bus_ready;

endmodule
